// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch squash,
// multi-cycle data-memory waits, halt freeze, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_rs_addr,
  input  logic [3:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [3:0]       ex_dst_addr,
  input  logic             ex_is_load,
  input  logic             br_taken_ex,
  input  logic             mem_access,
  input  logic             hlt_wb,
  output logic             pc_stall,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  localparam bit HAS_MEM = (MEM_LAT > 0);
  localparam int WAIT_W  = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  // The access cycle in RUN is the first stall cycle, so MEM_WAIT covers the remaining ones.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = HAS_MEM ? WAIT_W'(MEM_LAT - 1) : '0;

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_next_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_load_use;
  logic w_stall_all;
  logic w_lu_stall;
  logic w_flush_if_id;
  logic w_flush_id_ex;
  logic w_pc_stall;

  assign w_load_use = ex_is_load && (ex_dst_addr != 4'd0) &&
                      ((id_uses_rs && (id_rs_addr == ex_dst_addr)) ||
                       (id_uses_rt && (id_rt_addr == ex_dst_addr)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_stall_all     = 1'b0;
    w_lu_stall      = 1'b0;
    w_flush_if_id   = 1'b0;
    w_flush_id_ex   = 1'b0;
    if (r_state == HALTED) begin
      w_stall_all = 1'b1;
    end else if (hlt_wb) begin
      w_stall_all  = 1'b1;
      w_next_state = HALTED;
    end else if ((r_state == MEM_WAIT) && (r_wait_cnt != '0)) begin
      w_stall_all     = 1'b1;
      w_next_wait_cnt = r_wait_cnt - WAIT_W'(1);
    end else if ((r_state == RUN) && HAS_MEM && mem_access) begin
      w_stall_all     = 1'b1;
      w_next_state    = MEM_WAIT;
      w_next_wait_cnt = WAIT_LOAD;
    end else begin
      // RUN, or the MEM_WAIT release cycle: branch squash outranks the load-use bubble.
      w_next_state = RUN;
      if (br_taken_ex) begin
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
      end else if (w_load_use) begin
        w_lu_stall    = 1'b1;
        w_flush_id_ex = 1'b1;
      end
    end
  end

  assign w_pc_stall = w_stall_all | w_lu_stall;

  // NOTE: controls are masked by rst_n so the banks see no stall/flush while reset is held.
  assign pc_stall     = rst_n & w_pc_stall;
  assign stall_if_id  = rst_n & w_pc_stall;
  assign stall_id_ex  = rst_n & w_stall_all;
  assign stall_ex_mem = rst_n & w_stall_all;
  assign stall_mem_wb = rst_n & w_stall_all;
  assign flush_if_id  = rst_n & w_flush_if_id;
  assign flush_id_ex  = rst_n & w_flush_id_ex;
  assign halted       = (r_state == HALTED);
  assign stall_cnt    = r_stall_cnt;

  // NOTE: sequential state uses non-blocking assignments and the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if (w_pc_stall && (r_state != HALTED) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (MEM_LAT=3/CNT_W=16, MEM_LAT=3/CNT_W=4,
// MEM_LAT=0/CNT_W=16) share stimulus and are compared each cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rs_addr, id_rt_addr, ex_dst_addr;
  logic       id_uses_rs, id_uses_rt, ex_is_load, br_taken_ex, mem_access, hlt_wb;

  always #5 clk = ~clk;

  // Packed control outputs: {pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
  logic [6:0]  ctl_a  [3];
  logic        halt_a [3];
  logic [15:0] cnt_a  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LATG = (g == 2) ? 0 : 3;
    localparam int CWG  = (g == 1) ? 4 : 16;
    logic ps, sif, sie, sem, smw, fif, fie, hl;
    logic [CWG-1:0] sc;
    pipeline_hazard_ctrl #(.MEM_LAT(LATG), .CNT_W(CWG)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_rs_addr  (id_rs_addr),
      .id_rt_addr  (id_rt_addr),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .ex_dst_addr (ex_dst_addr),
      .ex_is_load  (ex_is_load),
      .br_taken_ex (br_taken_ex),
      .mem_access  (mem_access),
      .hlt_wb      (hlt_wb),
      .pc_stall    (ps),
      .stall_if_id (sif),
      .stall_id_ex (sie),
      .stall_ex_mem(sem),
      .stall_mem_wb(smw),
      .flush_if_id (fif),
      .flush_id_ex (fie),
      .halted      (hl),
      .stall_cnt   (sc)
    );
    assign ctl_a[g]  = {ps, sif, sie, sem, smw, fif, fie};
    assign halt_a[g] = hl;
    assign cnt_a[g]  = 16'(sc);
  end

  // Model: stall cycles still owed for the current access, a "just released" flag, halt, count.
  typedef struct {
    int mem_left;
    bit rel;
    bit halted;
    int cnt;
  } mstate_t;

  typedef struct {
    logic [3:0] rs, rt, dst;
    logic       urs, urt, ld, br;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] ALL_STALL = 7'b1111100;
  localparam logic [6:0] BR_FLUSH  = 7'b0000011;
  localparam logic [6:0] LU_RESP   = 7'b1100001;

  mstate_t m [3];
  mstate_t m_nxt [3];
  vec_t    vt [9];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  int      c0;
  logic [15:0] cf;

  function automatic int lat_of(input int k);
    return (k == 2) ? 0 : 3;
  endfunction

  function automatic int cmax_of(input int k);
    return (k == 1) ? 15 : 65535;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hazard();
    return ex_is_load && (ex_dst_addr != 0) &&
           ((id_uses_rs && id_rs_addr == ex_dst_addr) || (id_uses_rt && id_rt_addr == ex_dst_addr));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m[k] = '{0, 1'b0, 1'b0, 0};
  endtask

  task automatic clr_inputs();
    id_rs_addr = '0; id_rt_addr = '0; ex_dst_addr = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_is_load = 0;
    br_taken_ex = 0; mem_access = 0; hlt_wb = 0;
  endtask

  // Called just after a falling edge: let inputs settle, compare every instance, plan next state.
  task automatic settle();
    #1;
    for (int k = 0; k < 3; k++) begin
      mstate_t s, n;
      logic [6:0] e;
      s = m[k];
      n = s;
      e = '0;
      if (s.halted) begin
        e = ALL_STALL;
      end else if (hlt_wb) begin
        e = ALL_STALL;
        n.halted = 1'b1;
      end else if (s.mem_left > 0) begin
        e = ALL_STALL;
        n.mem_left = s.mem_left - 1;
        n.rel = (n.mem_left == 0);
      end else if (lat_of(k) > 0 && mem_access && !s.rel) begin
        e = ALL_STALL;
        n.mem_left = lat_of(k) - 1;
        n.rel = (lat_of(k) == 1);
      end else begin
        n.rel = 1'b0;
        if (br_taken_ex) e = BR_FLUSH;
        else if (hazard()) e = LU_RESP;
      end
      if (e[6] && !s.halted && s.cnt < cmax_of(k)) n.cnt = s.cnt + 1;
      m_nxt[k] = n;
      check($sformatf("model_ctl[%0d]", k), 32'(ctl_a[k]), 32'(e));
      check($sformatf("model_halted[%0d]", k), 32'(halt_a[k]), 32'(s.halted));
      check($sformatf("model_cnt[%0d]", k), 32'(cnt_a[k]), 32'(s.cnt));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m = m_nxt;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    id_rs_addr  = 4'($urandom_range(0, 3));
    id_rt_addr  = 4'($urandom_range(0, 3));
    ex_dst_addr = 4'($urandom_range(0, 3));
    id_uses_rs  = 1'($urandom_range(0, 1));
    id_uses_rt  = 1'($urandom_range(0, 1));
    ex_is_load  = 1'($urandom_range(0, 1));
    br_taken_ex = ($urandom_range(0, 4) == 0);
    mem_access  = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    vt[0] = '{rs:3, rt:0, dst:3, urs:1, urt:0, ld:1, br:0, exp:LU_RESP};
    vt[1] = '{rs:3, rt:0, dst:0, urs:1, urt:0, ld:1, br:0, exp:7'b0};
    vt[2] = '{rs:0, rt:0, dst:0, urs:1, urt:1, ld:1, br:0, exp:7'b0};
    vt[3] = '{rs:1, rt:5, dst:5, urs:1, urt:1, ld:1, br:0, exp:LU_RESP};
    vt[4] = '{rs:1, rt:5, dst:5, urs:1, urt:0, ld:1, br:0, exp:7'b0};
    vt[5] = '{rs:7, rt:0, dst:7, urs:1, urt:0, ld:0, br:0, exp:7'b0};
    vt[6] = '{rs:3, rt:0, dst:3, urs:1, urt:0, ld:1, br:1, exp:BR_FLUSH};
    vt[7] = '{rs:3, rt:4, dst:4, urs:1, urt:0, ld:1, br:0, exp:7'b0};
    vt[8] = '{rs:15, rt:15, dst:15, urs:1, urt:1, ld:1, br:0, exp:LU_RESP};

    clr_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_ctl", 32'(ctl_a[0]), 32'd0);
    check("reset_halted", 32'(halt_a[0]), 32'd0);
    check("reset_cnt", 32'(cnt_a[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      id_rs_addr = vt[i].rs; id_rt_addr = vt[i].rt; ex_dst_addr = vt[i].dst;
      id_uses_rs = vt[i].urs; id_uses_rt = vt[i].urt;
      ex_is_load = vt[i].ld; br_taken_ex = vt[i].br;
      settle();
      check($sformatf("vec_%0d", i), 32'(ctl_a[0]), 32'(vt[i].exp));
      advance();
      clr_inputs();
    end

    // Load-use bubble lasts one cycle once the hazard clears.
    id_rs_addr = 3; ex_dst_addr = 3; id_uses_rs = 1; ex_is_load = 1;
    settle();
    check("lu_first", 32'(ctl_a[0]), 32'(LU_RESP));
    advance();
    clr_inputs();
    settle();
    check("lu_one_cycle", 32'(ctl_a[0]), 32'd0);
    advance();

    // Back-to-back memory accesses with mem_access held high.
    c0 = int'(cnt_a[0]);
    mem_access = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("mem_seq_%0d", i), 32'(ctl_a[0][6]), 32'(pat[i]));
      if (pat[i] == 1) check($sformatf("mem_all_%0d", i), 32'(ctl_a[0]), 32'(ALL_STALL));
      if (i == 4) check("mem_cnt_first", 32'(cnt_a[0]), 32'(c0 + 3));
      advance();
    end
    check("mem_cnt_second", 32'(cnt_a[0]), 32'(c0 + 6));
    clr_inputs();
    settle();
    advance();

    // Taken branch held through a memory wait: flush only in the release cycle.
    mem_access = 1; br_taken_ex = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) mem_access = 0;
      if (i == 4) br_taken_ex = 0;
      settle();
      check($sformatf("br_wait_flush_%0d", i), 32'(ctl_a[0][1:0]), (i == 3) ? 32'd3 : 32'd0);
      advance();
    end

    // Reset in the middle of a memory wait.
    mem_access = 1;
    settle();
    advance();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 32'(ctl_a[0]), 32'd0);
    check("rst_mid_cnt", 32'(cnt_a[0]), 32'd0);
    model_reset();
    clr_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    check("rst_release_idle", 32'(ctl_a[0]), 32'd0);
    advance();
    mem_access = 1;
    settle();
    check("run_after_reset", 32'(ctl_a[0]), 32'(ALL_STALL));
    advance();
    clr_inputs();

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      settle();
      advance();
    end
    check("cnt4_saturated", 32'(cnt_a[1]), 32'd15);

    // Halt: immediate full stall, sticky freeze, counter frozen.
    clr_inputs();
    hlt_wb = 1;
    settle();
    check("halt_same_cycle", 32'(ctl_a[0]), 32'(ALL_STALL));
    check("halt_not_yet", 32'(halt_a[0]), 32'd0);
    advance();
    hlt_wb = 0;
    settle();
    check("halted_next", 32'(halt_a[0]), 32'd1);
    cf = cnt_a[0];
    advance();
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      hlt_wb = 1'($urandom_range(0, 1));
      settle();
      check($sformatf("halt_hold_%0d", i), 32'(ctl_a[0]), 32'(ALL_STALL));
      check($sformatf("halt_sticky_%0d", i), 32'(halt_a[0]), 32'd1);
      check($sformatf("halt_cnt_%0d", i), 32'(cnt_a[0]), 32'(cf));
      advance();
    end

    rst_n = 1'b0;
    #1;
    check("final_rst_halted", 32'(halt_a[0]), 32'd0);
    check("final_rst_ctl", 32'(ctl_a[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
